// File: rtl/block_matmul_scheduler.sv
// Block-index sequencer for an N x N matrix product built from one 2x2 block multiplier
// and a block accumulator. Walks (i, j, k) with k innermost and issues fetch/mul/acc/write.
module block_matmul_scheduler #(
  parameter int unsigned BLOCKS  = 2,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] blk_i,
  output logic [IDX_W-1:0] blk_j,
  output logic [IDX_W-1:0] blk_k,
  output logic             fetch,
  input  logic             fetch_valid,
  output logic             mul_start,
  input  logic             mul_done,
  output logic             acc_start,
  output logic             acc_first,
  input  logic             acc_done,
  output logic             wr_en
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(BLOCKS - 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StWaitOps,
    StMul,
    StWaitMul,
    StAcc,
    StWaitAcc,
    StWrite,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StWaitOps;
      StWaitOps: begin
        if (fetch_valid) state_d = StMul;
      end
      StMul: begin
        cnt_d   = '0;
        state_d = StWaitMul;
      end
      StWaitMul: begin
        if (mul_done) begin
          state_d = StAcc;
        end else if (TIMEOUT != 0) begin
          // Abort the whole product when the multiplier never answers.
          if (cnt_q == TimeoutVal - CntW'(1)) begin
            err_d   = 1'b1;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StAcc: state_d = StWaitAcc;
      StWaitAcc: begin
        if (acc_done) begin
          if (k_q == LastIdx) begin
            k_d     = '0;
            state_d = StWrite;
          end else begin
            k_d     = k_q + IDX_W'(1);
            state_d = StFetch;
          end
        end
      end
      StWrite: begin
        if (i_q == LastIdx && j_q == LastIdx) begin
          state_d = StDone;
        end else begin
          if (j_q == LastIdx) begin
            j_d = '0;
            i_d = i_q + IDX_W'(1);
          end else begin
            j_d = j_q + IDX_W'(1);
          end
          state_d = StFetch;
        end
      end
      StDone: begin
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign fetch     = (state_q == StFetch);
  assign mul_start = (state_q == StMul);
  assign acc_start = (state_q == StAcc);
  assign acc_first = (state_q == StAcc) && (k_q == '0);
  assign wr_en     = (state_q == StWrite);
  assign done      = (state_q == StDone);
  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign error     = err_q;
  assign blk_i     = i_q;
  assign blk_j     = j_q;
  assign blk_k     = k_q;

endmodule
